stream_mux_rr: RTL
==================

// Module: stream_mux_rr
//
// PURPOSE
//  N-channel, W-bit stream multiplexer with valid/ready handshakes. This is the
//  registered successor of the combinational 2:1/4:1 muxes in this section.
//  Each cycle it picks one requesting input channel, by round-robin or fixed
//  priority, and moves that beat into a single output register. The register
//  is tagged with the source channel index. Sits between several producers
//  and one consumer.
//
// PARAMETERS
//  N_CH = 4  number of input channels (>= 2)
//  W    = 8  data width per channel, bits (>= 1)
//  RR   = 1  1: round-robin arbitration; 0: fixed priority, lowest index wins
//  CW   = $clog2(N_CH)  derived channel-index width (localparam, not settable)
//
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous reset, active low
//  in_valid   in   N_CH     per-channel valid
//  in_data    in   N_CH*W   channel i occupies bits [i*W +: W]
//  in_ready   out  N_CH     per-channel ready, at most one bit high
//  out_valid  out  1        output register holds a beat
//  out_data   out  W        data of held beat
//  out_ch     out  CW       source channel of held beat
//  out_ready  in   1        consumer accepts the beat when out_valid && out_ready
//
// BEHAVIOUR
//  - Reset (rst_n low, async, immediate): out_valid=0, out_data=0, out_ch=0,
//    RR pointer last=N_CH-1 (so ch0 has first priority). A held beat is discarded.
//  - load = !out_valid || out_ready  (register empty, or draining this cycle).
//  - Grant (combinational):
//    - If load && |in_valid: exactly one channel g is granted.
//    - RR=1: g = first i with in_valid[i], scanning last+1, last+2, ...
//      with wrap mod N_CH.
//    - RR=0: g = lowest i with in_valid[i].
//  - in_ready[g]=1 only for the granted channel; all other bits 0.
//    in_ready is 0 for every channel when !load or when no channel is valid.
//  - A transfer on channel g happens when in_valid[g] && in_ready[g]. On that
//    clock edge: out_data<=in_data[g], out_ch<=g, out_valid<=1; if RR=1, last<=g.
//  - Drain without refill (out_valid && out_ready, no input transfer):
//    out_valid<=0; out_data/out_ch keep their old values.
//  - Simultaneous drain + refill: the new beat replaces the old one in the same
//    edge, out_valid stays 1. Full throughput is one beat per cycle.
//  - Latency: an accepted input appears on out_* the next cycle.
//  - Backpressure: out_valid && !out_ready holds out_* stable, in_ready all 0,
//    and the pointer does not move.
//  - The pointer moves only on a transfer; idle cycles do not rotate it.
//    Wrap: last=N_CH-1 searches from 0.
//  - Fairness (RR=1): a continuously valid channel is granted within N_CH
//    transfers.
//  - No combinational path from out_ready to out_*. in_ready depends on
//    in_valid, out_valid, out_ready and last.
//
// TESTING (N_CH=4, W=8 unless noted)
//  1 Reset mid-stream: out_valid=1, ch2 held, assert rst_n=0 between edges ->
//    out_valid=0 immediately; after release, ch0..3 all valid -> ch0 granted first.
//  2 RR rotation: all 4 valid every cycle, out_ready=1, data=8'hA0+i ->
//    out_ch sequence 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0.
//  3 Backpressure: out_ready=0 for 3 cycles with ch1 held ->
//    out_data/out_ch stable, in_ready=4'b0000; out_ready=1 -> next beat loads in
//    the same edge, no bubble.
//  4 Sparse RR + wrap: last=2, only ch1 and ch3 valid -> ch3 granted, then ch1.
//    Idle cycles with in_valid=0 do not change order.
//  5 Fixed priority (RR=0): ch0 and ch3 valid for 4 cycles -> ch0 granted every
//    cycle and ch3 starves; drop ch0 -> ch3 granted the next cycle.
//  6 Drain to empty: single beat ch1=8'h5C, then in_valid=0 with out_ready=1 ->
//    out_valid 1 for exactly one cycle, then 0; out_data stays 8'h5C.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N_CH-input, W-bit registered stream multiplexer with valid/ready handshakes.
//   Each cycle one requesting channel is granted, either round-robin or by fixed
//   priority (lowest index wins). The granted beat moves into a single output
//   register that is tagged with its source channel index.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous reset, active low
//   in_valid   [N_CH]    per-channel valid
//   in_data    [N_CH*W]  channel i occupies bits [i*W +: W]
//   in_ready   [N_CH]    per-channel ready, one-hot or zero
//   out_valid            output register holds a beat
//   out_data   [W]       data of the held beat
//   out_ch     [CW]      source channel of the held beat
//   out_ready            consumer accepts when out_valid && out_ready
module stream_mux_rr #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8,
    parameter bit          RR   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*W-1:0]        in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(N_CH)-1:0]  out_ch,
    input  logic                     out_ready
);

    localparam int unsigned CW = $clog2(N_CH);

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q,  data_d;
    logic [CW-1:0] ch_q,    ch_d;
    logic [CW-1:0] last_q,  last_d;

    logic          load;
    logic          found;
    logic [CW-1:0] gnt;
    logic [W-1:0]  ch_data [N_CH];

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_data[i] = in_data[i*W +: W];
        end
    end

    // Register may accept a new beat when empty or being drained this cycle;
    // out_ready only steers in_ready and the next state, never out_* directly.
    assign load = !valid_q || out_ready;

    // Scan N_CH positions starting just after the last granted channel (RR)
    // or from channel 0 (fixed priority); the first valid one wins.
    always_comb begin
        int unsigned   idx;
        logic [CW-1:0] idx_c;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        idx_c = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (RR) begin
                idx = (32'(last_q) + 1 + k) % N_CH;
            end else begin
                idx = k;
            end
            idx_c = CW'(idx);
            if (!found && in_valid[idx_c]) begin
                found = 1'b1;
                gnt   = idx_c;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load && found) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        if (load && found) begin
            valid_d = 1'b1;
            data_d  = ch_data[gnt];
            ch_d    = gnt;
            if (RR) begin
                last_d = gnt;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= CW'(N_CH - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule
